// File: rtl/video_console.sv
// video_console: ASCII text-console writer for the video_main display memory.
// Optional feature macro VIDEO_CONSOLE_ATTR_EN: ESC <byte> loads the attribute.
module video_console #(
   parameter int          COLS         = 40,
   parameter int          ROWS         = 20,
   parameter logic [7:0]  DEFAULT_ATTR = 8'h0F,
   parameter logic [7:0]  FILL_CHAR    = 8'h20,
   parameter int          AW           = $clog2(COLS * ROWS),
   parameter int          CW           = $clog2(COLS),
   parameter int          RW           = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          reset_ni,
   input  logic          char_valid_i,
   input  logic [7:0]    char_data_i,
   output logic          char_ready_o,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [15:0]   wr_data_o,
   output logic [CW-1:0] cursor_col_o,
   output logic [RW-1:0] cursor_row_o,
   output logic          busy_o
);

`ifdef VIDEO_CONSOLE_ATTR_EN
   typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE, ESC_ATTR} state_t;
`else
   typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] col_d;
   logic [RW-1:0] row_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] clr_q, clr_d;
   logic          wr_en_d, busy_d;
   logic [AW-1:0] addr_d;
   logic [15:0]   data_d;
   logic [7:0]    attr;
   logic          accept;

`ifdef VIDEO_CONSOLE_ATTR_EN
   logic [7:0] attr_d;
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) attr <= DEFAULT_ATTR;
      else           attr <= attr_d;
   end
`else
   assign attr = DEFAULT_ATTR;
`endif

   always_comb begin
      char_ready_o = (state_q == IDLE);
`ifdef VIDEO_CONSOLE_ATTR_EN
      char_ready_o = char_ready_o || (state_q == ESC_ATTR);
`endif
   end

   assign accept = char_valid_i && char_ready_o;

   always_comb begin
      state_d = state_q;
      col_d   = cursor_col_o;
      row_d   = cursor_row_o;
      base_d  = base_q;
      clr_d   = clr_q;
      wr_en_d = 1'b0;
      busy_d  = 1'b0;
      addr_d  = wr_addr_o;
      data_d  = wr_data_o;
`ifdef VIDEO_CONSOLE_ATTR_EN
      attr_d  = attr;
`endif
      unique case (state_q)
         CLR_ALL: begin
            wr_en_d = 1'b1;
            busy_d  = 1'b1;
            addr_d  = clr_q;
            data_d  = {attr, FILL_CHAR};
            clr_d   = clr_q + 1'b1;
            if (clr_q == AW'(ROWS * COLS - 1)) begin
               state_d = IDLE;
               clr_d   = '0;
               col_d   = '0;
               row_d   = '0;
               base_d  = '0;
            end
         end
         CLR_LINE: begin
            wr_en_d = 1'b1;
            busy_d  = 1'b1;
            addr_d  = base_q + clr_q;
            data_d  = {attr, FILL_CHAR};
            clr_d   = clr_q + 1'b1;
            if (clr_q == AW'(COLS - 1)) begin
               state_d = IDLE;
               clr_d   = '0;
            end
         end
`ifdef VIDEO_CONSOLE_ATTR_EN
         ESC_ATTR: begin
            if (accept) begin
               attr_d  = char_data_i;
               state_d = IDLE;
            end
         end
`endif
         IDLE: begin
            if (accept) begin
               unique case (1'b1)
                  (char_data_i >= 8'h20 && char_data_i <= 8'h7E): begin
                     wr_en_d = 1'b1;
                     addr_d  = base_q + AW'(cursor_col_o);
                     data_d  = {attr, char_data_i};
                     col_d   = cursor_col_o + 1'b1;
                     if (cursor_col_o == CW'(COLS - 1)) begin
                        col_d   = '0;
                        state_d = CLR_LINE;
                     end
                  end
                  (char_data_i == 8'h0D): col_d = '0;
                  (char_data_i == 8'h0A): state_d = CLR_LINE;
                  (char_data_i == 8'h08): begin
                     if (cursor_col_o != '0) col_d = cursor_col_o - 1'b1;
                  end
                  (char_data_i == 8'h0C): state_d = CLR_ALL;
`ifdef VIDEO_CONSOLE_ATTR_EN
                  (char_data_i == 8'h1B): state_d = ESC_ATTR;
`endif
                  default: ;
               endcase
               // every path into CLR_LINE from IDLE is a row advance
               if (state_d == CLR_LINE) begin
                  if (cursor_row_o == RW'(ROWS - 1)) begin
                     row_d  = '0;
                     base_d = '0;
                  end else begin
                     row_d  = cursor_row_o + 1'b1;
                     base_d = base_q + AW'(COLS);
                  end
               end
            end
         end
         default: state_d = CLR_ALL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= CLR_ALL;
         cursor_col_o <= '0;
         cursor_row_o <= '0;
         base_q       <= '0;
         clr_q        <= '0;
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         busy_o       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cursor_col_o <= col_d;
         cursor_row_o <= row_d;
         base_q       <= base_d;
         clr_q        <= clr_d;
         wr_en_o      <= wr_en_d;
         wr_addr_o    <= addr_d;
         wr_data_o    <= data_d;
         busy_o       <= busy_d;
      end
   end

endmodule
